// File: rtl/multi_timer_control.sv
// N-channel kitchen timer control: one program/load/run/pause/done FSM per channel,
// buttons steered by sel. Optional alarm self-clear is enabled with `define ALARM_TIMEOUT_EN.
module multi_timer_control #(
  parameter int CHANNELS    = 4,
  parameter int CH_W        = 2,
  parameter int ALARM_TICKS = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic [CH_W-1:0]       sel,
  input  logic                  cooktime_req,
  input  logic                  start_timer,
  input  logic                  pause_req,
  input  logic                  timer_en,
  input  logic [CHANNELS-1:0]   timer_done,
  input  logic                  seconds_req,
  input  logic                  minutes_req,
  input  logic                  alarm_ack,
  output logic [CHANNELS-1:0]   increment_seconds,
  output logic [CHANNELS-1:0]   increment_minutes,
  output logic [CHANNELS-1:0]   prog_mode,
  output logic [CHANNELS-1:0]   load_timer,
  output logic [CHANNELS-1:0]   main_timer_enable,
  output logic [CHANNELS-1:0]   timer_enabled_led,
  output logic [CHANNELS-1:0]   timer_on_led,
  output logic                  alarm,
  output logic [CH_W-1:0]       alarm_chan,
  output logic [3*CHANNELS-1:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PROG  = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [CHANNELS-1:0] sel_hit;
  logic [CHANNELS-1:0] flash_q, flash_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] set_alarm, clr_alarm, timeout;

  // An out-of-range sel leaves sel_hit all zero, so no channel sees the buttons.
  always_comb begin
    sel_hit = '0;
    for (int ch = 0; ch < CHANNELS; ch++) sel_hit[ch] = (int'(sel) == ch);
  end

  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      state_d[ch] = state_q[ch];
      case (state_q[ch])
        IDLE: begin
          if (sel_hit[ch] && cooktime_req)     state_d[ch] = PROG;
          else if (sel_hit[ch] && start_timer) state_d[ch] = LOAD;
        end
        PROG: begin
          if (sel_hit[ch] && start_timer) state_d[ch] = LOAD;
        end
        LOAD: state_d[ch] = RUN;
        RUN: begin
          if (sel_hit[ch] && cooktime_req)   state_d[ch] = PROG;
          else if (timer_done[ch])           state_d[ch] = DONE;
          else if (sel_hit[ch] && pause_req) state_d[ch] = PAUSE;
        end
        PAUSE: begin
          if (sel_hit[ch] && cooktime_req)     state_d[ch] = PROG;
          else if (sel_hit[ch] && pause_req)   state_d[ch] = RUN;
          else if (sel_hit[ch] && start_timer) state_d[ch] = LOAD;
        end
        DONE: begin
          if (sel_hit[ch] && cooktime_req)     state_d[ch] = PROG;
          else if (sel_hit[ch] && start_timer) state_d[ch] = LOAD;
        end
        default: state_d[ch] = IDLE;
      endcase
    end
  end

  always_comb begin
    prog_mode         = '0;
    load_timer        = '0;
    main_timer_enable = '0;
    state_dbg         = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      prog_mode[ch]         = (state_q[ch] == PROG);
      load_timer[ch]        = (state_q[ch] == LOAD);
      main_timer_enable[ch] = (state_q[ch] == RUN) && timer_en;
      state_dbg[3*ch +: 3]  = state_q[ch];
    end
    increment_seconds = prog_mode & sel_hit & {CHANNELS{seconds_req}};
    increment_minutes = prog_mode & sel_hit & {CHANNELS{minutes_req}};
    timer_enabled_led = main_timer_enable;
    timer_on_led      = main_timer_enable & flash_q;
  end

  // Flash only survives while staying in RUN; any other next state drops it.
  always_comb begin
    flash_d   = '0;
    set_alarm = '0;
    clr_alarm = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (state_d[ch] == RUN)
        flash_d[ch] = (main_timer_enable[ch] && tick) ? ~flash_q[ch] : flash_q[ch];
      set_alarm[ch] = (state_q[ch] == RUN) && (state_d[ch] == DONE);
      clr_alarm[ch] = (sel_hit[ch] && alarm_ack) ||
                      ((state_q[ch] == DONE) && (state_d[ch] != DONE));
    end
    pend_d = set_alarm | (pend_q & ~clr_alarm & ~timeout);
  end

`ifdef ALARM_TIMEOUT_EN
  localparam int CNT_W = $clog2(ALARM_TICKS + 1);
  logic [CNT_W-1:0] cnt_q [CHANNELS];

  always_comb begin
    timeout = '0;
    for (int ch = 0; ch < CHANNELS; ch++)
      timeout[ch] = pend_q[ch] && tick && (cnt_q[ch] == CNT_W'(ALARM_TICKS - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int ch = 0; ch < CHANNELS; ch++) cnt_q[ch] <= '0;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (set_alarm[ch])             cnt_q[ch] <= '0;
        else if (pend_q[ch] && tick)   cnt_q[ch] <= cnt_q[ch] + CNT_W'(1);
      end
    end
  end
`else
  assign timeout = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int ch = 0; ch < CHANNELS; ch++) state_q[ch] <= IDLE;
      flash_q <= '0;
      pend_q  <= '0;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) state_q[ch] <= state_d[ch];
      flash_q <= flash_d;
      pend_q  <= pend_d;
    end
  end

  // Scan downward so the lowest pending index is the last one written.
  always_comb begin
    alarm_chan = '0;
    for (int ch = CHANNELS - 1; ch >= 0; ch--)
      if (pend_q[ch]) alarm_chan = CH_W'(ch);
  end

  assign alarm = |pend_q;

endmodule

// File: tb/tb_multi_timer_control.sv
// Bench for multi_timer_control: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural channel model.
module tb_multi_timer_control;
  localparam int CH = 3;
  localparam int CW = 2;
  localparam int AT = 8;
  localparam int S_IDLE = 0, S_PROG = 1, S_LOAD = 2, S_RUN = 3, S_PAUSE = 4, S_DONE = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          tick, cooktime_req, start_timer, pause_req, timer_en;
  logic          seconds_req, minutes_req, alarm_ack;
  logic [CW-1:0] sel;
  logic [CH-1:0] timer_done;
  logic [CH-1:0] increment_seconds, increment_minutes, prog_mode, load_timer;
  logic [CH-1:0] main_timer_enable, timer_enabled_led, timer_on_led;
  logic          alarm;
  logic [CW-1:0] alarm_chan;
  logic [3*CH-1:0] state_dbg;

  int vectors = 0;
  int errors  = 0;

  multi_timer_control #(.CHANNELS(CH), .CH_W(CW), .ALARM_TICKS(AT)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .sel(sel), .cooktime_req(cooktime_req),
    .start_timer(start_timer), .pause_req(pause_req), .timer_en(timer_en),
    .timer_done(timer_done), .seconds_req(seconds_req), .minutes_req(minutes_req),
    .alarm_ack(alarm_ack), .increment_seconds(increment_seconds),
    .increment_minutes(increment_minutes), .prog_mode(prog_mode), .load_timer(load_timer),
    .main_timer_enable(main_timer_enable), .timer_enabled_led(timer_enabled_led),
    .timer_on_led(timer_on_led), .alarm(alarm), .alarm_chan(alarm_chan), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model of every channel
  int m_st    [CH];
  bit m_flash [CH];
  bit m_pend  [CH];
  int m_cnt   [CH];

  function automatic int next_st(int cur, bit s, bit d);
    int nx;
    nx = cur;
    case (cur)
      S_IDLE:  if (s && cooktime_req) nx = S_PROG; else if (s && start_timer) nx = S_LOAD;
      S_PROG:  if (s && start_timer) nx = S_LOAD;
      S_LOAD:  nx = S_RUN;
      S_RUN:   if (s && cooktime_req) nx = S_PROG; else if (d) nx = S_DONE;
               else if (s && pause_req) nx = S_PAUSE;
      S_PAUSE: if (s && cooktime_req) nx = S_PROG; else if (s && pause_req) nx = S_RUN;
               else if (s && start_timer) nx = S_LOAD;
      S_DONE:  if (s && cooktime_req) nx = S_PROG; else if (s && start_timer) nx = S_LOAD;
      default: nx = S_IDLE;
    endcase
    return nx;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int ch = 0; ch < CH; ch++) begin
        m_st[ch] = S_IDLE; m_flash[ch] = 0; m_pend[ch] = 0; m_cnt[ch] = 0;
      end
    end else begin
      for (int ch = 0; ch < CH; ch++) begin
        bit s;
        int cur, nx;
        s   = (int'(sel) == ch);
        cur = m_st[ch];
        nx  = next_st(cur, s, timer_done[ch]);
        if (nx != S_RUN) m_flash[ch] = 0;
        else if (cur == S_RUN && timer_en && tick) m_flash[ch] = !m_flash[ch];
        if (cur == S_RUN && nx == S_DONE) begin
          m_pend[ch] = 1; m_cnt[ch] = 0;
        end else if ((s && alarm_ack) || (cur == S_DONE && nx != S_DONE)) begin
          m_pend[ch] = 0;
        end
`ifdef ALARM_TIMEOUT_EN
        else if (m_pend[ch] && tick) begin
          m_cnt[ch]++;
          if (m_cnt[ch] >= AT) m_pend[ch] = 0;
        end
`endif
        m_st[ch] = nx;
      end
    end
  end

  function automatic logic [63:0] exp_out();
    logic [CH-1:0] pm, lt, mte, on, is, im;
    logic          al;
    logic [CW-1:0] ac;
    bit            found;
    pm = '0; lt = '0; mte = '0; on = '0; is = '0; im = '0; al = 0; ac = '0; found = 0;
    for (int ch = 0; ch < CH; ch++) begin
      pm[ch]  = (m_st[ch] == S_PROG);
      lt[ch]  = (m_st[ch] == S_LOAD);
      mte[ch] = (m_st[ch] == S_RUN) && timer_en;
      on[ch]  = mte[ch] && m_flash[ch];
      is[ch]  = pm[ch] && (int'(sel) == ch) && seconds_req;
      im[ch]  = pm[ch] && (int'(sel) == ch) && minutes_req;
      if (m_pend[ch]) begin
        al = 1;
        if (!found) begin ac = CW'(ch); found = 1; end
      end
    end
    return 64'({is, im, pm, lt, mte, mte, on, al, ac});
  endfunction

  function automatic logic [63:0] act_out();
    return 64'({increment_seconds, increment_minutes, prog_mode, load_timer,
                main_timer_enable, timer_enabled_led, timer_on_led, alarm, alarm_chan});
  endfunction

  // scoreboard: every cycle, well after inputs settle and before the next edge
  always @(negedge clk) begin
    #3;
    chk("outputs_vs_model", act_out(), exp_out());
  end

  // driver tasks
  task automatic clr();
    start_timer = 0; pause_req = 0; alarm_ack = 0; seconds_req = 0;
    minutes_req = 0; tick = 0; timer_done = '0;
  endtask

  task automatic nxt();
    @(negedge clk);
    clr();
  endtask

`ifdef ALARM_TIMEOUT_EN
  localparam logic ALARM_AFTER_TIMEOUT = 1'b0;
`else
  localparam logic ALARM_AFTER_TIMEOUT = 1'b1;
`endif

  initial begin
    reset_n = 0; sel = '0; cooktime_req = 0; timer_en = 0;
    clr();
    #1 chk("reset_outputs", act_out(), 64'd0);
    @(negedge clk) reset_n = 1;
    #1 chk("post_release_outputs", act_out(), 64'd0);

    // program channel 1 and bump seconds three times
    nxt(); sel = 1; cooktime_req = 1;
    nxt(); #1 chk("t1_prog_mode", prog_mode, 3'b010);
    repeat (3) begin
      nxt(); seconds_req = 1;
      #1 chk("t1_inc_sec_pulse", increment_seconds, 3'b010);
      chk("t1_inc_min_quiet", increment_minutes, 3'b000);
      nxt(); #1 chk("t1_inc_sec_low", increment_seconds, 3'b000);
    end

    // load and run channel 1, flash follows ticks
    nxt(); cooktime_req = 0; start_timer = 1; timer_en = 1;
    nxt(); #1 chk("t2_load", load_timer, 3'b010);
    chk("t2_mte_during_load", main_timer_enable, 3'b000);
    nxt(); #1 chk("t2_load_gone", load_timer, 3'b000);
    chk("t2_mte", main_timer_enable, 3'b010);
    nxt(); tick = 1; #1 chk("t2_led_before_tick", timer_on_led, 3'b000);
    nxt(); #1 chk("t2_led_after_tick1", timer_on_led, 3'b010);
    tick = 1;
    nxt(); #1 chk("t2_led_after_tick2", timer_on_led, 3'b000);

    // channels 1 and 2 finish together
    nxt(); sel = 2; start_timer = 1;
    nxt();
    nxt(); timer_done = 3'b110;
    nxt(); #1 chk("t3_alarm", alarm, 1'b1);
    chk("t3_alarm_chan1", alarm_chan, 2'd1);
    nxt(); sel = 1; alarm_ack = 1;
    nxt(); #1 chk("t3_alarm_chan2", alarm_chan, 2'd2);
    chk("t3_alarm_still", alarm, 1'b1);
    nxt(); sel = 2; alarm_ack = 1;
    nxt(); #1 chk("t3_alarm_clear", alarm, 1'b0);

    // channel 0 pause toggle, then done beats pause
    nxt(); sel = 0; start_timer = 1;
    nxt();
    nxt(); #1 chk("t4_run", main_timer_enable, 3'b001);
    pause_req = 1;
    nxt(); #1 chk("t4_paused", main_timer_enable, 3'b000);
    pause_req = 1;
    nxt(); #1 chk("t4_resumed", main_timer_enable, 3'b001);
    pause_req = 1; timer_done = 3'b001;
    nxt(); #1 chk("t4_done_alarm", alarm, 1'b1);
    chk("t4_done_chan", alarm_chan, 2'd0);
    pause_req = 1;
    nxt(); #1 chk("t4_not_paused", main_timer_enable, 3'b000);

    // unacknowledged alarm on channel 0 against tick count
    repeat (7) begin tick = 1; nxt(); end
    #1 chk("t6_alarm_after_7", alarm, 1'b1);
    tick = 1;
    nxt(); #1 chk("t6_alarm_after_8", alarm, ALARM_AFTER_TIMEOUT);

    // sel beyond the channel count selects nothing
    nxt(); sel = 3; cooktime_req = 1; start_timer = 1; pause_req = 1;
    alarm_ack = 1; seconds_req = 1; minutes_req = 1;
    #1 chk("t5_inc_sec", increment_seconds, 3'b000);
    chk("t5_inc_min", increment_minutes, 3'b000);
    nxt(); cooktime_req = 0;
    #1 chk("t5_prog", prog_mode, 3'b000);
    chk("t5_load", load_timer, 3'b000);
    chk("t5_alarm_kept", alarm, ALARM_AFTER_TIMEOUT);

    // asynchronous reset in the middle of RUN
    nxt(); sel = 1; start_timer = 1;
    nxt();
    nxt();
    nxt(); #1 chk("t7_run_before_reset", main_timer_enable, 3'b010);
    #1 reset_n = 0;
    #1 chk("t7_async_reset", act_out(), 64'd0);
    @(negedge clk) reset_n = 1;
    clr();

    // randomized traffic
    repeat (3000) begin
      nxt();
      sel          = CW'($urandom_range(0, 3));
      cooktime_req = ($urandom_range(0, 7) == 0);
      start_timer  = ($urandom_range(0, 5) == 0);
      pause_req    = ($urandom_range(0, 4) == 0);
      timer_en     = ($urandom_range(0, 7) != 0);
      tick         = ($urandom_range(0, 2) == 0);
      alarm_ack    = ($urandom_range(0, 9) == 0);
      seconds_req  = $urandom_range(0, 1) == 1;
      minutes_req  = $urandom_range(0, 1) == 1;
      for (int ch = 0; ch < CH; ch++) timer_done[ch] = ($urandom_range(0, 7) == 0);
    end
    nxt();
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
